// File: rtl/z_norm_check.sv
// z_norm_check: streams the decoded z vector out of memory over two read
// ports and flags any coefficient whose centered magnitude reaches the bound.

package z_norm_check_pkg;
    localparam int unsigned ABR_MEM_ADDR_WIDTH = 15;
    localparam int unsigned MEM_ADDR_WIDTH     = ABR_MEM_ADDR_WIDTH;

    typedef enum logic [1:0] {
        RW_IDLE  = 2'b00,
        RW_READ  = 2'b01,
        RW_WRITE = 2'b10
    } mem_rw_mode_e;

    typedef struct packed {
        mem_rw_mode_e                rd_wr_en;
        logic [MEM_ADDR_WIDTH-1:0]   addr;
    } mem_if_t;
endpackage

module z_norm_check
    import z_norm_check_pkg::*;
#(
    parameter int unsigned REG_SIZE = 24,
    parameter int unsigned Q        = 8380417,
    parameter int unsigned BOUND    = 524168,
    parameter int unsigned NUM_ADDR = 448
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           zeroize,
    input  logic [MEM_ADDR_WIDTH-1:0]      src_base_addr,
    output mem_if_t                        mem_a_rd_req,
    output mem_if_t                        mem_b_rd_req,
    input  logic [3:0][REG_SIZE-1:0]       mem_a_rd_data,
    input  logic [3:0][REG_SIZE-1:0]       mem_b_rd_data,
    input  logic                           norm_check_enable,
    output logic                           norm_check_done,
    output logic                           invalid
);

    localparam int unsigned CNT_W = $clog2(NUM_ADDR + 1);
    localparam logic [CNT_W-1:0]    LAST_PAIR = CNT_W'(NUM_ADDR - 2);
    localparam logic [CNT_W-1:0]    CNT_STEP  = CNT_W'(2);
    localparam logic [REG_SIZE-1:0] Q_W       = REG_SIZE'(Q);
    localparam logic [REG_SIZE-1:0] HALF_Q_W  = REG_SIZE'((Q - 1) / 2);
    localparam logic [REG_SIZE-1:0] BOUND_W   = REG_SIZE'(BOUND);
    localparam mem_if_t             REQ_IDLE  = '{rd_wr_en: RW_IDLE, addr: '0};

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        DRAIN = 2'b10
    } state_e;

    state_e                     state_q, state_d;
    logic [CNT_W-1:0]           rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0]           chk_cnt_q, chk_cnt_d;
    logic [MEM_ADDR_WIDTH-1:0]  locked_addr_q, locked_addr_d;
    mem_if_t                    mem_a_rd_req_q, mem_a_rd_req_d;
    mem_if_t                    mem_b_rd_req_q, mem_b_rd_req_d;
    logic                       data_valid_q, data_valid_d;
    logic                       invalid_q, invalid_d;
    logic                       done_q, done_d;
    logic                       any_fail_c;

    // Out-of-range values fail outright; otherwise fold into [0, (Q-1)/2] and compare.
    function automatic logic coef_fail(input logic [REG_SIZE-1:0] c);
        logic [REG_SIZE-1:0] mag;
        logic                fail;
        mag = (c > HALF_Q_W) ? (Q_W - c) : c;
        if (c >= Q_W) begin
            fail = 1'b1;
        end else begin
            fail = (mag >= BOUND_W);
        end
        return fail;
    endfunction

    // OR of the norm check across all eight lanes of the returned pair.
    always_comb begin
        any_fail_c = 1'b0;
        for (int i = 0; i < 4; i++) begin
            any_fail_c = any_fail_c | coef_fail(mem_a_rd_data[i]) | coef_fail(mem_b_rd_data[i]);
        end
    end

    // Next-state, request generation and result accumulation.
    always_comb begin
        state_d        = state_q;
        rd_cnt_d       = rd_cnt_q;
        chk_cnt_d      = chk_cnt_q;
        locked_addr_d  = locked_addr_q;
        mem_a_rd_req_d = REQ_IDLE;
        mem_b_rd_req_d = REQ_IDLE;
        data_valid_d   = (mem_a_rd_req_q.rd_wr_en == RW_READ);
        invalid_d      = invalid_q;
        done_d         = 1'b0;

        // Returned data is consumed regardless of state; it only arrives while scanning.
        if (data_valid_q) begin
            invalid_d = invalid_q | any_fail_c;
            chk_cnt_d = chk_cnt_q + CNT_STEP;
            if (chk_cnt_q == LAST_PAIR) begin
                done_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (norm_check_enable) begin
                    state_d       = READ;
                    locked_addr_d = src_base_addr;
                    invalid_d     = 1'b0;
                    rd_cnt_d      = '0;
                    chk_cnt_d     = '0;
                end
            end
            READ: begin
                mem_a_rd_req_d = '{rd_wr_en: RW_READ,
                                   addr: locked_addr_q + MEM_ADDR_WIDTH'(rd_cnt_q)};
                mem_b_rd_req_d = '{rd_wr_en: RW_READ,
                                   addr: locked_addr_q + MEM_ADDR_WIDTH'(rd_cnt_q)
                                         + MEM_ADDR_WIDTH'(1)};
                rd_cnt_d = rd_cnt_q + CNT_STEP;
                if (rd_cnt_q == LAST_PAIR) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Held through the done cycle so a start coinciding with done is ignored.
                if (done_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (zeroize) begin
            state_d        = IDLE;
            rd_cnt_d       = '0;
            chk_cnt_d      = '0;
            locked_addr_d  = '0;
            mem_a_rd_req_d = REQ_IDLE;
            mem_b_rd_req_d = REQ_IDLE;
            data_valid_d   = 1'b0;
            invalid_d      = 1'b0;
            done_d         = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            rd_cnt_q       <= '0;
            chk_cnt_q      <= '0;
            locked_addr_q  <= '0;
            mem_a_rd_req_q <= REQ_IDLE;
            mem_b_rd_req_q <= REQ_IDLE;
            data_valid_q   <= 1'b0;
            invalid_q      <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            rd_cnt_q       <= rd_cnt_d;
            chk_cnt_q      <= chk_cnt_d;
            locked_addr_q  <= locked_addr_d;
            mem_a_rd_req_q <= mem_a_rd_req_d;
            mem_b_rd_req_q <= mem_b_rd_req_d;
            data_valid_q   <= data_valid_d;
            invalid_q      <= invalid_d;
            done_q         <= done_d;
        end
    end

    assign mem_a_rd_req    = mem_a_rd_req_q;
    assign mem_b_rd_req    = mem_b_rd_req_q;
    assign norm_check_done = done_q;
    assign invalid         = invalid_q;

endmodule
